// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative 32-bit multiply/divide unit with architectural HI/LO.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, both on operand
// magnitudes. A sign fix-up cycle follows, and MTHI/MTLO write HI/LO directly.
module multdiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_a_q, neg_a_d;
  logic        dzero_q, dzero_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;

  // Helper datapath signals
  logic        op_arith;
  logic        op_signed;
  logic        op_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] div_next;
  logic [63:0] prod_neg;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Operand decode, magnitudes, and one iteration of multiply/divide
  always_comb begin
    op_arith  = (op[2] == 1'b0);
    op_signed = (op[0] == 1'b0);
    op_div    = op[1];
    a_mag     = (op_signed && rs_data[31]) ? (~rs_data + 32'd1) : rs_data;
    b_mag     = (op_signed && rt_data[31]) ? (~rt_data + 32'd1) : rt_data;

    // Multiply step: conditionally add the multiplicand into the upper half,
    // then shift the 65-bit {carry, product} right by one.
    mul_sum   = {1'b0, prod_q[63:32]} + {1'b0, (prod_q[0] ? mcand_q : 32'd0)};
    mul_next  = {mul_sum, prod_q[31:1]};

    // Divide step: prod_q holds {remainder, dividend/quotient}; the shifted
    // partial remainder is 33 bits, but a successful trial result always fits
    // in 32 bits because it is less than the divisor.
    div_shift = {prod_q[63:32], prod_q[31]};
    div_ge    = (div_shift >= {1'b0, mcand_q});
    div_rem   = div_ge ? (div_shift[31:0] - mcand_q) : div_shift[31:0];
    div_next  = {div_rem, prod_q[30:0], div_ge};

    prod_neg  = ~prod_q + 64'd1;
    quo_fix   = (neg_res_q && !dzero_q) ? (~prod_q[31:0] + 32'd1) : prod_q[31:0];
    rem_fix   = neg_a_q ? (~prod_q[63:32] + 32'd1) : prod_q[63:32];
  end

  // Next-state and register update logic for the IDLE/CALC/FIX sequence
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    dzero_d   = dzero_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_arith) begin
            state_d   = S_CALC;
            busy_d    = 1'b1;
            cnt_d     = '0;
            is_div_d  = op_div;
            neg_res_d = op_signed && (rs_data[31] ^ rt_data[31]);
            neg_a_d   = op_signed && rs_data[31];
            dzero_d   = (rt_data == '0);
            mcand_d   = b_mag;
            prod_d    = {32'd0, a_mag};
          end else if (op == OP_MTHI) begin
            hi_d = rs_data;
          end else if (op == OP_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      S_CALC: begin
        prod_d = is_div_q ? div_next : mul_next;
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else if (neg_res_q) begin
          hi_d = prod_neg[63:32];
          lo_d = prod_neg[31:0];
        end else begin
          hi_d = prod_q[63:32];
          lo_d = prod_q[31:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset overrides everything including FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      dzero_q   <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      dzero_q   <= dzero_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench for multdiv_unit. Expected HI/LO pairs are
// queued at issue and popped when done pulses; timing is checked per operation.
module tb_multdiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_done   = 0;
  int          n_exp    = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;

  multdiv_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Scoreboard: compare HI/LO against the oldest queued expectation on done
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sb_hi", hi, e.hi);
        check_eq("sb_lo", lo, e.lo);
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    int lat;
    int bcnt;
    bit got;
    exp_q.push_back('{hi: eh, lo: el});
    n_exp++;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) got = 1'b1;
      if (lat == 10) begin
        check_eq("hold_hi", hi, m_hi);
        check_eq("hold_lo", lo, m_lo);
      end
    end
    check_eq("done_latency", 32'(lat), 32'd34);
    check_eq("busy_cycles", 32'(bcnt), 32'd33);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    int lat;
    bit got;

    rst = 1'b1; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);

    // Directed cases
    do_op(MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    do_op(MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    do_op(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op(DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    do_op(DIVU,  32'h64,       32'd0,        32'h64,       32'hFFFFFFFF);
    do_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    do_op(DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    do_op(DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);

    // Randomised cases with bench-computed results
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      p = {32'd0, a} * {32'd0, b};
      do_op(MULTU, a, b, p[63:32], p[31:0]);
      p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      do_op(MULT, a, b, p[63:32], p[31:0]);
      b = (b >> (i * 8)) | 32'd1;
      do_op(DIVU, a, b, a % b, a / b);
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      sq = $signed(a) / $signed(b);
      sr = $signed(a) % $signed(b);
      do_op(DIV, a, b, sr, sq);
    end

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = MTHI; rs_data = 32'h12345678;
    @(negedge clk);
    check_eq("mthi_hi", hi, 32'h12345678);
    op = MTLO; rs_data = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    check_eq("mt_hi", hi, 32'h12345678);
    check_eq("mt_lo", lo, 32'h9ABCDEF0);
    check_eq("mt_busy", 32'(busy), 32'd0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

    // Issue while busy is ignored, including MTHI
    exp_q.push_back('{hi: 32'd0, lo: 32'd12});
    n_exp++;
    @(negedge clk);
    start = 1'b1; op = MULT; rs_data = 32'd3; rt_data = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = MTHI; rs_data = 32'h0000DEAD;
    @(negedge clk);
    op = MULT; rs_data = 32'd7; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check_eq("ign_hi", hi, 32'h12345678);
    check_eq("ign_busy", 32'(busy), 32'd1);
    lat = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
    end
    check_eq("ign_done_seen", 32'(got), 32'd1);
    repeat (40) @(negedge clk);
    check_eq("ign_final_hi", hi, 32'd0);
    check_eq("ign_final_lo", lo, 32'd12);

    // Reset in the middle of CALC aborts with no result
    @(negedge clk);
    start = 1'b1; op = MULT; rs_data = 32'd3; rt_data = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_hi", hi, 32'd0);
    check_eq("abort_lo", lo, 32'd0);
    m_hi = '0; m_lo = '0;
    repeat (40) @(negedge clk);
    do_op(DIVU, 32'd9, 32'd3, 32'd0, 32'd3);

    repeat (3) @(negedge clk);
    check_eq("done_count", 32'(n_done), 32'(n_exp));
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
